// File: rtl/load_store_unit.sv
// Load/store unit: one core load or store at a time over a simple req/ack memory port.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses without touching memory.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic [1:0]  ssrc,
    input  logic [2:0]  lwsrc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [7:0] WAIT_LAST = 8'd254;

    function automatic logic [1:0] load_size(input logic [2:0] lw);
        case (lw[1:0])
            2'b00:   load_size = SZ_BYTE;
            2'b01:   load_size = SZ_HALF;
            default: load_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: replicate = {4{wd[7:0]}};
            SZ_HALF: replicate = {2{wd[15:0]}};
            default: replicate = wd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] lw, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (lw)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = word;
        endcase
    endfunction

    state_t      state_r, state_nxt;
    logic [7:0]  cnt_r, cnt_nxt;
    logic [2:0]  lwsrc_r;
    logic [1:0]  lane_r;
    logic        is_load_r;
    logic        done_r, done_nxt;
    logic        err_r, err_nxt;
    logic [31:0] rdata_r;
    logic        m_req_r, m_we_r;
    logic [31:0] m_addr_r, m_wdata_r;
    logic [3:0]  m_be_r;

    logic [1:0]  size_s;
    logic        misalign_s;
    logic        launch_s;
    logic        capture_s;

    // Access size and alignment of the request currently presented by the core.
    always_comb begin
        size_s = mem_write ? ((ssrc == 2'b00) ? SZ_BYTE :
                              (ssrc == 2'b01) ? SZ_HALF : SZ_WORD)
                           : load_size(lwsrc);
`ifdef MISALIGN_TRAP_EN
        misalign_s = ((size_s == SZ_HALF) && addr[0]) ||
                     ((size_s == SZ_WORD) && (addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
    end

    // Next-state and transfer control.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        launch_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (misalign_s) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_REQ;
                        cnt_nxt   = 8'd0;
                        launch_s  = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (m_ack) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    capture_s = 1'b1;
                end else if (cnt_r == WAIT_LAST) begin
                    // 255th unanswered cycle: give up and report a timeout
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, request latch, memory-port and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            lwsrc_r   <= 3'd0;
            lane_r    <= 2'd0;
            is_load_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'd0;
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= 32'd0;
            m_be_r    <= 4'd0;
            m_wdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            m_req_r <= (state_nxt == ST_REQ);
            m_we_r  <= (state_nxt == ST_REQ) && (launch_s ? mem_write : m_we_r);
            if (launch_s) begin
                lwsrc_r   <= lwsrc;
                lane_r    <= addr[1:0];
                is_load_r <= ~mem_write;
                m_addr_r  <= {addr[31:2], 2'b00};
                m_be_r    <= lane_mask(size_s, addr[1:0]);
                m_wdata_r <= replicate(size_s, wdata);
            end
            if (capture_s && is_load_r) begin
                rdata_r <= extract(lwsrc_r, lane_r, m_rdata);
            end
        end
    end

    assign busy    = ((state_r == ST_IDLE) && start) || (state_r == ST_REQ);
    assign done    = done_r;
    assign err     = err_r;
    assign rdata   = rdata_r;
    assign m_req   = m_req_r;
    assign m_we    = m_we_r;
    assign m_addr  = m_addr_r;
    assign m_be    = m_be_r;
    assign m_wdata = m_wdata_r;

endmodule
